// File: rtl/pers_dispatch.sv
// Dispatch front end of the personality: AEG register file, start/done handshake
// with the accelerator core, and a busy-cycle counter exposed as AEG NUM_AEG.
module pers_dispatch #(
    parameter int         NUM_AEG    = 16,
    parameter logic [4:0] START_INST = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        disp_inst_vld,
    input  logic [4:0]  disp_inst,
    input  logic [17:0] disp_aeg_idx,
    input  logic        disp_aeg_rd,
    input  logic        disp_aeg_wr,
    input  logic [63:0] disp_aeg_wr_data,
    output logic [17:0] disp_aeg_cnt,
    output logic [15:0] disp_exception,
    output logic        disp_idle,
    output logic        disp_rtn_data_vld,
    output logic [63:0] disp_rtn_data,
    output logic        disp_stall,
    output logic        accel_start,
    input  logic        accel_done,
    input  logic [17:0] accel_rd_idx,
    output logic [63:0] accel_rd_data,
    input  logic        accel_wr_vld,
    input  logic [17:0] accel_wr_idx,
    input  logic [63:0] accel_wr_data,
    output logic [63:0] busy_cycles
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [17:0] AEG_LIMIT = 18'(NUM_AEG);

    state_t      state, state_nxt;
    logic [63:0] aeg [NUM_AEG];
    logic [63:0] disp_rd_val;
    logic [1:0]  exc_q;
    logic        start_go;
    logic        bad_inst;
    logic        bad_aeg;
    logic        disp_wr_ok;

    assign disp_aeg_cnt   = 18'(NUM_AEG + 1);
    assign disp_idle      = (state == IDLE);
    assign disp_stall     = (state == BUSY);
    assign disp_exception = {14'b0, exc_q};

    // Instructions presented while stalled are dropped, never flagged.
    assign start_go   = disp_inst_vld && !disp_stall && (disp_inst == START_INST);
    assign bad_inst   = disp_inst_vld && !disp_stall && (disp_inst != START_INST);
    assign disp_wr_ok = disp_aeg_wr && (disp_aeg_idx < AEG_LIMIT);
    assign bad_aeg    = (disp_aeg_wr && (disp_aeg_idx >= AEG_LIMIT)) ||
                        (disp_aeg_rd && (disp_aeg_idx > AEG_LIMIT));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_go)   state_nxt = BUSY;
            BUSY:    if (accel_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            accel_start <= 1'b0;
            busy_cycles <= 64'd0;
            exc_q       <= 2'b00;
        end else begin
            state       <= state_nxt;
            accel_start <= start_go;
            exc_q       <= {bad_aeg, bad_inst};
            if (start_go)
                busy_cycles <= 64'd0;
            else if (state == BUSY)
                busy_cycles <= busy_cycles + 64'd1;
        end
    end

    // Dispatch write takes priority over a core write-back to the same index.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_AEG; i++) aeg[i] <= 64'd0;
        end else begin
            for (int i = 0; i < NUM_AEG; i++) begin
                if (disp_wr_ok && (disp_aeg_idx == 18'(i)))
                    aeg[i] <= disp_aeg_wr_data;
                else if (accel_wr_vld && (accel_wr_idx == 18'(i)))
                    aeg[i] <= accel_wr_data;
            end
        end
    end

    always_comb begin
        disp_rd_val = 64'd0;
        if (disp_aeg_idx == AEG_LIMIT) disp_rd_val = busy_cycles;
        for (int i = 0; i < NUM_AEG; i++)
            if (disp_aeg_idx == 18'(i)) disp_rd_val = aeg[i];
    end

    always_comb begin
        accel_rd_data = 64'd0;
        for (int i = 0; i < NUM_AEG; i++)
            if (accel_rd_idx == 18'(i)) accel_rd_data = aeg[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_rtn_data_vld <= 1'b0;
            disp_rtn_data     <= 64'd0;
        end else begin
            disp_rtn_data_vld <= disp_aeg_rd;
            if (disp_aeg_rd) disp_rtn_data <= disp_rd_val;
        end
    end

endmodule

// File: doc/pers_dispatch.md
# pers_dispatch

Dispatch-side front end of the personality: it terminates the Convey dispatch interface driven into `cae_pers` and owns the application engine register (AEG) file. It turns the start instruction into a one-cycle start pulse for the accelerator core and holds dispatch stalled until the core reports completion. It also exposes AEG contents to the core, accepts result write-back from the core, and counts busy cycles into a read-only AEG.

## Interface
Parameters:
- `NUM_AEG`, 16: number of read/write AEGs, indices 0..NUM_AEG-1. Range is 1..1024.
- `START_INST`, 5'd0: `disp_inst` opcode that launches the core.

Ports:
- `clk` in 1: personality clock.
- `reset` in 1: synchronous, active-high reset.
- `disp_inst_vld` in 1: instruction dispatch valid.
- `disp_inst` in 5: instruction opcode.
- `disp_aeg_idx` in 18: AEG index.
- `disp_aeg_rd` in 1: AEG read request.
- `disp_aeg_wr` in 1: AEG write request.
- `disp_aeg_wr_data` in 64: AEG write data.
- `disp_aeg_cnt` out 18: number of AEGs, constant NUM_AEG+1.
- `disp_exception` out 16: exception flags. Bit0 is unimplemented instruction, bit1 is bad AEG access, others are 0.
- `disp_idle` out 1: high when the block is in IDLE.
- `disp_rtn_data_vld` out 1: read return valid.
- `disp_rtn_data` out 64: read return data.
- `disp_stall` out 1: dispatch stall.
- `accel_start` out 1: one-cycle start pulse to the core.
- `accel_done` in 1: one-cycle completion pulse from the core.
- `accel_rd_idx` in 18: core read index, combinational read.
- `accel_rd_data` out 64: AEG[accel_rd_idx]. Reads 0 when the index is out of range.
- `accel_wr_vld` in 1: core write-back valid.
- `accel_wr_idx` in 18: core write-back index.
- `accel_wr_data` in 64: core write-back data.
- `busy_cycles` out 64: the busy counter (AEG NUM_AEG).

## Operation
- **States:**
  - IDLE → BUSY on `disp_inst_vld` with `disp_inst`==START_INST.
  - BUSY → IDLE on `accel_done`.
  - `accel_done` is ignored in IDLE.
- **Instruction handling:**
  - An instruction in BUSY is not possible, because `disp_stall`=1 in BUSY. If `disp_inst_vld` is asserted while `disp_stall`=1, it is ignored.
  - A non-START opcode while IDLE does not change state and sets `disp_exception[0]` for one cycle.
- **AEG write (dispatch):**
  - idx<NUM_AEG writes AEG[idx].
  - idx>=NUM_AEG (including the counter register) writes nothing and sets `disp_exception[1]` for one cycle.
  - Dispatch writes are accepted in any state and are never stalled.
- **AEG read (dispatch):**
  - idx<NUM_AEG returns AEG[idx].
  - idx==NUM_AEG returns `busy_cycles`.
  - idx>NUM_AEG returns 0 and sets `disp_exception[1]`.
- **Core write-back:**
  - `accel_wr_vld` with idx<NUM_AEG writes AEG[idx]. Out-of-range indices are dropped silently.
  - If dispatch and core write the same index in the same cycle, the dispatch write wins. If they write different indices, both writes occur.
- **Counter:**
  - `busy_cycles` clears to 0 on the IDLE→BUSY transition.
  - It increments by 1 each cycle in BUSY, including the `accel_done` cycle.
  - It wraps modulo 2^64 and holds its value in IDLE.
- **Simultaneous events:**
  - A read and a write to the same index in the same cycle return the old value.
  - `disp_aeg_rd` and `disp_aeg_wr` together are both honoured.
  - Exception bits from the same cycle are OR'd.

## Timing
- **Reset values:**
  - All AEGs and `busy_cycles` are 0.
  - State is IDLE, so `disp_idle`=1 and `disp_stall`=0.
  - `accel_start`, `disp_rtn_data_vld` and `disp_exception` are 0, and `disp_rtn_data` is 0.
- **Reset mid-operation:** reset in BUSY returns the block to IDLE the next cycle. No `accel_start` is issued and any pending return is discarded.
- **Start latency:** a START instruction accepted in cycle N gives:
  - `accel_start`=1 in cycle N+1 only;
  - `disp_idle`=0 and `disp_stall`=1 from N+1;
  - `busy_cycles`=0 in N+1.
- **Done latency:** `accel_done` in cycle M (BUSY) gives IDLE from M+1, with `disp_idle`=1 and `disp_stall`=0 in M+1.
- **Read latency:** a read in cycle N gives `disp_rtn_data_vld`=1 with data in N+1 only. `disp_rtn_data` holds its last value when not valid.
- **Write latency:** a write in cycle N is visible to reads issued in N+1.
- **Exceptions:** registered; they assert in N+1 for one cycle.
- **Combinational outputs:**
  - `accel_rd_data` is combinational from the registers and reflects writes one cycle after the write.
  - `disp_idle`, `disp_stall` and `busy_cycles` are register outputs.

## Test plan
- **Reset:** reset for 3 cycles, then read AEG0..AEG16 (NUM_AEG=16) → each return 0, one cycle after its read, `disp_idle`=1, `disp_aeg_cnt`=17.
- **Write/read:**
  - Write AEG3=64'hDEAD_BEEF_0123_4567 in cycle N, read AEG3 in N+1 → `disp_rtn_data_vld` in N+2 with that value.
  - Write AEG16 → `disp_exception`=16'h0002 for one cycle and AEG16 stays 0.
- **Start/done:**
  - START in cycle 10 → `accel_start` in cycle 11 only, with `disp_stall`=1.
  - `accel_done` in cycle 20 → `disp_idle`=1 in cycle 21.
  - Read AEG16 → 10.
- **Write-back collision:** in BUSY, dispatch writes AEG2=5 and core writes AEG2=9 in the same cycle → read returns 5. Core write AEG4=7 → `accel_rd_idx`=4 gives 7 next cycle.
- **Bad instruction:** opcode 5'd7 in IDLE → `disp_exception`=16'h0001 for one cycle, state stays IDLE, no `accel_start`.
- **Reset mid-operation:** reset 5 cycles after START → IDLE and `disp_stall`=0 after reset. A later `accel_done` is ignored, and a new START works normally.
